// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared types and constants for the slot machine sequencer
package slot_pkg;

  localparam int DIGIT_W     = 3;
  localparam int CREDIT_W    = 8;
  localparam int CREDIT_MAX  = 255;
  localparam int PAIR_PAY    = 2;
  localparam int JACKPOT_PAY = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN3 = 3'd1,
    SPIN2 = 3'd2,
    SPIN1 = 3'd3,
    EVAL  = 3'd4,
    SHOW  = 3'd5
  } state_t;

  // True while at least one reel is still turning
  function automatic logic is_spin(input state_t s);
    return (s == SPIN3) || (s == SPIN2) || (s == SPIN1);
  endfunction

  // States whose tick counter advances on frame ticks
  function automatic logic counts_ticks(input state_t s);
    return is_spin(s) || (s == SHOW);
  endfunction

endpackage

// File: rtl/slot_reel.sv
// rtl/slot_reel.sv - one reel: animated digit, latch-on-stop, spinning flag
module slot_reel
  import slot_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               step,
  input  logic               stop,
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] digit,
  output logic               spinning
);

  // Stop wins over animation so the latched digit is exactly the random value
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      digit    <= '0;
      spinning <= 1'b0;
    end else if (stop) begin
      digit    <= din;
      spinning <= 1'b0;
    end else if (start) begin
      spinning <= 1'b1;
    end else if (step && spinning) begin
      digit    <= digit + 1'b1;
    end
  end

endmodule

// File: rtl/slot_reel_controller.sv
// rtl/slot_reel_controller.sv - game sequencer: spin/stop control, evaluation, credits
module slot_reel_controller
  import slot_pkg::*;
#(
  parameter int SPIN_DIV    = 4,
  parameter int AUTO_TICKS  = 120,
  parameter int SHOW_TICKS  = 60,
  parameter int CREDIT_INIT = 10
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                tick,
  input  logic                btn_spin,
  input  logic                btn_stop,
  input  logic [DIGIT_W-1:0]  rnd,
  output logic                rnd_en,
  output logic [DIGIT_W-1:0]  reel0,
  output logic [DIGIT_W-1:0]  reel1,
  output logic [DIGIT_W-1:0]  reel2,
  output logic [2:0]          spinning,
  output logic [CREDIT_W-1:0] credits,
  output logic                win_pair,
  output logic                win_jackpot,
  output logic                busy
);

  localparam int CNT_W = 8;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    anim;
  logic                in_spin, spin_ok, timeout, stop_evt, anim_step;
  logic [2:0]          stop_sel;
  logic                jack, pair;
  logic [CREDIT_W:0]   payout, credit_sum;
  logic [CREDIT_W-1:0] credit_paid;

  assign in_spin   = is_spin(state);
  assign spin_ok   = (state == IDLE) && btn_spin && (credits != '0);
  assign timeout   = in_spin && (cnt == CNT_W'(AUTO_TICKS));
  // A button press and a timeout in the same cycle collapse into one stop
  assign stop_evt  = in_spin && (btn_stop || timeout);
  assign anim_step = in_spin && tick && (anim == CNT_W'(SPIN_DIV - 1));
  assign stop_sel  = {stop_evt && (state == SPIN1),
                      stop_evt && (state == SPIN2),
                      stop_evt && (state == SPIN3)};

  assign jack = (reel0 == reel1) && (reel1 == reel2);
  assign pair = !jack && ((reel0 == reel1) || (reel1 == reel2));
  assign payout = jack ? (CREDIT_W+1)'(JACKPOT_PAY)
                : pair ? (CREDIT_W+1)'(PAIR_PAY) : '0;
  assign credit_sum  = {1'b0, credits} + payout;
  assign credit_paid = (credit_sum > (CREDIT_W+1)'(CREDIT_MAX))
                     ? CREDIT_W'(CREDIT_MAX) : credit_sum[CREDIT_W-1:0];

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (spin_ok)  state_next = SPIN3;
      SPIN3:   if (stop_evt) state_next = SPIN2;
      SPIN2:   if (stop_evt) state_next = SPIN1;
      SPIN1:   if (stop_evt) state_next = EVAL;
      EVAL:    state_next = SHOW;
      SHOW:    if (cnt == CNT_W'(SHOW_TICKS)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rnd_en = in_spin;
    busy   = (state != IDLE);
  end

  // Per-state tick counter; a tick landing on a transition belongs to the new state
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt <= '0;
    else if (state_next != state)
      cnt <= (tick && counts_ticks(state_next)) ? CNT_W'(1) : '0;
    else if (tick && counts_ticks(state))
      cnt <= cnt + 1'b1;
  end

  // Animation prescaler, restarted with each accepted spin
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      anim <= '0;
    else if (spin_ok)
      anim <= '0;
    else if (in_spin && tick)
      anim <= (anim == CNT_W'(SPIN_DIV - 1)) ? '0 : anim + 1'b1;
  end

  // Credit balance and registered result flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      credits     <= CREDIT_W'(CREDIT_INIT);
      win_pair    <= 1'b0;
      win_jackpot <= 1'b0;
    end else if (spin_ok) begin
      credits     <= credits - 1'b1;
      win_pair    <= 1'b0;
      win_jackpot <= 1'b0;
    end else if (state == EVAL) begin
      credits     <= credit_paid;
      win_pair    <= pair;
      win_jackpot <= jack;
    end
  end

  slot_reel u_reel0 (
    .clk(clk), .clr(clr), .start(spin_ok), .step(anim_step), .stop(stop_sel[0]),
    .din(rnd), .digit(reel0), .spinning(spinning[0])
  );

  slot_reel u_reel1 (
    .clk(clk), .clr(clr), .start(spin_ok), .step(anim_step), .stop(stop_sel[1]),
    .din(rnd), .digit(reel1), .spinning(spinning[1])
  );

  slot_reel u_reel2 (
    .clk(clk), .clr(clr), .start(spin_ok), .step(anim_step), .stop(stop_sel[2]),
    .din(rnd), .digit(reel2), .spinning(spinning[2])
  );

endmodule

// File: tb/tb_slot_reel_controller.sv
// tb/tb_slot_reel_controller.sv - scoreboard bench for slot_reel_controller
module tb_slot_reel_controller;

  localparam int AUTO_T = 120;
  localparam int SHOW_T = 60;

  logic       clk = 1'b0;
  logic       clr, tick, btn_spin, btn_stop;
  logic [2:0] rnd;
  logic       rnd_en, win_pair, win_jackpot, busy;
  logic [2:0] reel0, reel1, reel2, spinning;
  logic [7:0] credits;

  slot_reel_controller dut (
    .clk(clk), .clr(clr), .tick(tick), .btn_spin(btn_spin), .btn_stop(btn_stop),
    .rnd(rnd), .rnd_en(rnd_en), .reel0(reel0), .reel1(reel1), .reel2(reel2),
    .spinning(spinning), .credits(credits), .win_pair(win_pair),
    .win_jackpot(win_jackpot), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] r0, r1, r2;
    logic       pair, jack;
    logic [7:0] cred;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cred;
  logic       saw_wrap = 1'b0;
  logic       pend = 1'b0;
  logic [2:0] prev_spin = 3'b000;
  logic [2:0] prev_r0 = 3'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic sp, input logic st);
    tick = t; btn_spin = sp; btn_stop = st;
    @(posedge clk); #1;
    tick = 1'b0; btn_spin = 1'b0; btn_stop = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic push_game(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    exp_t e;
    int   pay;
    e.r0 = a; e.r1 = b; e.r2 = c;
    e.jack = (a == b) && (b == c);
    e.pair = !e.jack && ((a == b) || (b == c));
    pay = e.jack ? 20 : (e.pair ? 2 : 0);
    cred = (cred + pay > 255) ? 255 : cred + pay;
    e.cred = 8'(cred);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    cred = 10;
  endtask

  task automatic finish_show();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("rnd_en_show", rnd_en, 0);
    run_ticks(SHOW_T - 1);
    check("busy_show", busy, 1);
    run_ticks(1);
    check("busy_idle", busy, 0);
  endtask

  task automatic play(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    cyc(1'b0, 1'b1, 1'b0);
    cred = cred - 1;
    check("spin_start", spinning, 3'b111);
    check("rnd_en_spin", rnd_en, 1);
    rnd = a; cyc(1'b0, 1'b0, 1'b1);
    check("stop0", {spinning, reel0}, {3'b110, a});
    rnd = b; cyc(1'b0, 1'b0, 1'b1);
    check("stop1", {spinning, reel1}, {3'b100, b});
    rnd = c; push_game(a, b, c); cyc(1'b0, 1'b0, 1'b1);
    finish_show();
  endtask

  // Result monitor: pops an expectation one cycle after all reels stop
  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        check("res_reels", {reel0, reel1, reel2}, {sb[0].r0, sb[0].r1, sb[0].r2});
        check("res_pair", win_pair, sb[0].pair);
        check("res_jackpot", win_jackpot, sb[0].jack);
        check("res_credits", credits, sb[0].cred);
        sb.delete(0);
      end
    end
    pend <= !clr && busy && (spinning == 3'b000) && (prev_spin != 3'b000);
    if (prev_spin[0] && spinning[0] && reel0 != prev_r0) begin
      check("anim_step", reel0, (prev_r0 + 1) % 8);
      if (prev_r0 == 3'd7) saw_wrap <= 1'b1;
    end
    prev_spin <= spinning;
    prev_r0   <= reel0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; tick = 1'b0; btn_spin = 1'b0; btn_stop = 1'b0; rnd = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_reels", {reel0, reel1, reel2}, 0);
    check("rst_credits", credits, 10);
    check("rst_flags", {win_pair, win_jackpot, rnd_en, busy, spinning}, 0);
    clr = 1'b0;
    cred = 10;

    // Asynchronous abort in SPIN2, observed before any clock edge
    cyc(1'b0, 1'b1, 1'b0);
    rnd = 3'd5; cyc(1'b0, 1'b0, 1'b1);
    check("pre_abort_spin", spinning, 3'b110);
    run_ticks(3);
    @(negedge clk); #1;
    clr = 1'b1;
    #1;
    check("abort_reels", {reel0, reel1, reel2}, 0);
    check("abort_credits", credits, 10);
    check("abort_state", {busy, rnd_en, spinning}, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    cred = 10;

    play(3'd5, 3'd5, 3'd5);
    check("jackpot_credits", credits, 29);
    do_reset();
    play(3'd2, 3'd2, 3'd6);
    check("pair_credits", credits, 11);
    do_reset();
    play(3'd1, 3'd4, 3'd1);
    check("loss_credits", credits, 9);

    // Auto-stop sequence with animation running
    cyc(1'b0, 1'b1, 1'b0);
    cred = cred - 1;
    rnd = 3'd7;
    run_ticks(AUTO_T - 1); check("auto_111", spinning, 3'b111);
    run_ticks(1);          check("auto_110", {spinning, reel0}, {3'b110, 3'd7});
    run_ticks(AUTO_T - 1); check("auto_110b", spinning, 3'b110);
    run_ticks(1);          check("auto_100", {spinning, reel1}, {3'b100, 3'd7});
    rnd = 3'd0;
    push_game(3'd7, 3'd7, 3'd0);
    run_ticks(AUTO_T - 1); check("auto_100b", spinning, 3'b100);
    run_ticks(1);          check("auto_000", spinning, 3'b000);
    finish_show();
    check("anim_wrap_seen", saw_wrap, 1);

    // Stop coinciding with timeout, spin ignored while spinning
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    cred = cred - 1;
    cyc(1'b0, 1'b1, 1'b0);
    check("spin_ignored", {spinning, credits}, {3'b111, 8'd9});
    run_ticks(AUTO_T - 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("coinc_pre", spinning, 3'b111);
    rnd = 3'd4; cyc(1'b0, 1'b0, 1'b1);
    check("coinc_stop", {spinning, reel0}, {3'b110, 3'd4});
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("coinc_single", spinning, 3'b110);
    cyc(1'b0, 1'b0, 1'b1);
    push_game(3'd4, 3'd4, 3'd4);
    cyc(1'b0, 1'b0, 1'b1);
    finish_show();

    // Drain to zero credits, then a spin must be refused
    do_reset();
    repeat (10) play(3'd1, 3'd4, 3'd1);
    check("zero_credits", credits, 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("zero_refused", {busy, spinning, credits}, 0);

    // Build up to 250 then saturate on a jackpot
    do_reset();
    repeat (12) play(3'd3, 3'd3, 3'd3);
    repeat (12) play(3'd6, 3'd6, 3'd1);
    check("credits_250", credits, 250);
    play(3'd2, 3'd2, 3'd2);
    check("credits_sat", credits, 255);

    check("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
